// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 2-flop input synchronizer, mid-bit sampling, a one-byte
// holding register with valid/ready handoff, frame-error pulse and sticky overrun.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       UART_RXD,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

  logic       sync1_q;
  logic       rxs_q;
  state_e     state_q;
  logic [15:0] cnt_q;
  logic [2:0] idx_q;
  logic [7:0] shift_q;
  logic [7:0] data_q;
  logic       valid_q;
  logic       ferr_q;
  logic       ovr_q;
  logic       busy_q;
  logic       accept;

  // Synchronizer flops reset to the idle-high line level so reset never fakes a start bit.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= UART_RXD;
      rxs_q   <= sync1_q;
    end
  end

  assign accept = valid_q & rx_ready;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      if (accept) begin
        valid_q <= 1'b0;
        ovr_q   <= 1'b0;
      end
      // A commit below overrides the handshake clear, keeping valid high with new data.
      case (state_q)
        S_IDLE: begin
          if (!rxs_q) begin
            state_q <= S_START;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q <= '0;
            idx_q <= '0;
            if (!rxs_q) begin
              state_q <= S_DATA;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_DATA: begin
          if (cnt_q == FULL_M1) begin
            shift_q[idx_q] <= rxs_q;
            cnt_q          <= '0;
            if (idx_q == 3'd7) state_q <= S_STOP;
            else               idx_q   <= idx_q + 3'd1;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_STOP: begin
          if (cnt_q == FULL_M1) begin
            cnt_q <= '0;
            if (rxs_q) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
              if (valid_q && !rx_ready) ovr_q <= 1'b1;
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= S_BREAK;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_BREAK: begin
          if (rxs_q) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized bench for uart_rx at 8 clocks per bit; expected values come
// from a byte-level model of the holding register (data / valid / overrun).
module tb_uart_rx;

  localparam int CPB     = 8;
  localparam int EXP_LAT = 2 + CPB / 2 + 9 * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rise_cyc = 0;
  int rise_cnt = 0;
  int fe_cnt = 0;
  logic prev_valid = 1'b0;
  logic [7:0] rise_q[$];

  // Byte-level reference model of the holding register.
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ovr;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .UART_RXD (rxd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rx_valid && !prev_valid) begin
      rise_cnt++;
      rise_cyc = cyc;
      rise_q.push_back(rx_data);
    end
    if (frame_err) fe_cnt++;
    prev_valid = rx_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b, input int ncyc);
    rxd = b;
    repeat (ncyc) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    start_cyc = cyc;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
    drive_bit(stop, CPB);
  endtask

  task automatic pulse_ready();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int r0, f0, lat, diff;
    logic [7:0] b;
    logic       stop_ok;
    logic       exp_rise;

    reset    = 1'b1;
    rxd      = 1'b1;
    rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("reset_rx_data", {24'd0, rx_data}, 32'h00);
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_overrun", {31'd0, overrun}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);

    // Single frame, consumer not ready: latency and data.
    r0 = rise_cnt; f0 = fe_cnt;
    send_frame(8'hA5, 1'b1);
    repeat (2) @(negedge clk);
    lat  = rise_cyc - start_cyc - 1;
    diff = (lat > EXP_LAT) ? lat - EXP_LAT : EXP_LAT - lat;
    check("a5_rise_count", rise_cnt - r0, 1);
    check("a5_latency_within_1", {31'd0, diff <= 1}, 32'd1);
    check("a5_rx_data", {24'd0, rx_data}, 32'hA5);
    check("a5_rx_valid", {31'd0, rx_valid}, 32'd1);
    check("a5_frame_err_pulses", fe_cnt - f0, 0);
    check("a5_overrun", {31'd0, overrun}, 32'd0);

    // Second frame while unread: overwrite plus overrun; handshake clears both.
    send_frame(8'h3C, 1'b1);
    repeat (2) @(negedge clk);
    check("3c_rx_data", {24'd0, rx_data}, 32'h3C);
    check("3c_rx_valid", {31'd0, rx_valid}, 32'd1);
    check("3c_overrun", {31'd0, overrun}, 32'd1);
    pulse_ready();
    check("3c_valid_after_ack", {31'd0, rx_valid}, 32'd0);
    check("3c_overrun_after_ack", {31'd0, overrun}, 32'd0);

    // Framing error followed by a held-low line.
    r0 = rise_cnt; f0 = fe_cnt;
    send_frame(8'h55, 1'b0);
    repeat (40) @(negedge clk);
    check("brk_frame_err_pulses", fe_cnt - f0, 1);
    check("brk_no_valid", rise_cnt - r0, 0);
    check("brk_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("brk_busy_while_low", {31'd0, busy}, 32'd1);
    check("brk_rx_data_kept", {24'd0, rx_data}, 32'h3C);
    rxd = 1'b1;
    repeat (5) @(negedge clk);
    check("brk_busy_released", {31'd0, busy}, 32'd0);

    // Short glitch on an idle line.
    r0 = rise_cnt; f0 = fe_cnt;
    drive_bit(1'b0, 2);
    drive_bit(1'b1, 20);
    check("glitch_no_valid", rise_cnt - r0, 0);
    check("glitch_no_frame_err", fe_cnt - f0, 0);
    check("glitch_busy", {31'd0, busy}, 32'd0);

    // Back-to-back frames with the consumer always ready.
    rise_q.delete();
    r0 = rise_cnt;
    rx_ready = 1'b1;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    repeat (3) @(negedge clk);
    rx_ready = 1'b0;
    check("b2b_rise_count", rise_cnt - r0, 2);
    if (rise_q.size() == 2) begin
      check("b2b_first_byte", {24'd0, rise_q[0]}, 32'h00);
      check("b2b_second_byte", {24'd0, rise_q[1]}, 32'hFF);
    end
    check("b2b_overrun", {31'd0, overrun}, 32'd0);
    check("b2b_valid_drained", {31'd0, rx_valid}, 32'd0);

    // Reset during data bit 4, then a clean frame.
    r0 = rise_cnt; f0 = fe_cnt;
    b = 8'h81;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bit(b[i], CPB);
    drive_bit(b[4], CPB / 2);
    reset = 1'b1;
    rxd   = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (CPB * 10) @(negedge clk);
    check("abort_no_valid", rise_cnt - r0, 0);
    check("abort_no_frame_err", fe_cnt - f0, 0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    send_frame(8'h81, 1'b1);
    repeat (2) @(negedge clk);
    check("after_reset_rx_data", {24'd0, rx_data}, 32'h81);
    check("after_reset_rx_valid", {31'd0, rx_valid}, 32'd1);
    pulse_ready();

    // Randomized frames against the byte-level model.
    m_data  = 8'h81;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    for (int k = 0; k < 10; k++) begin
      b       = 8'($urandom);
      stop_ok = ($urandom_range(0, 3) != 0);
      r0 = rise_cnt; f0 = fe_cnt;
      exp_rise = stop_ok && !m_valid;
      send_frame(b, stop_ok);
      if (stop_ok) begin
        if (m_valid) m_ovr = 1'b1;
        m_data  = b;
        m_valid = 1'b1;
      end else begin
        repeat ($urandom_range(5, 30)) @(negedge clk);
        rxd = 1'b1;
        repeat (4) @(negedge clk);
      end
      repeat (2) @(negedge clk);
      check($sformatf("rnd%0d_rx_data", k), {24'd0, rx_data}, {24'd0, m_data});
      check($sformatf("rnd%0d_rx_valid", k), {31'd0, rx_valid}, {31'd0, m_valid});
      check($sformatf("rnd%0d_overrun", k), {31'd0, overrun}, {31'd0, m_ovr});
      check($sformatf("rnd%0d_frame_err", k), fe_cnt - f0, stop_ok ? 0 : 1);
      check($sformatf("rnd%0d_rise", k), rise_cnt - r0, exp_rise ? 1 : 0);
      if ($urandom_range(0, 1) == 1) begin
        pulse_ready();
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        check($sformatf("rnd%0d_ack_valid", k), {31'd0, rx_valid}, 32'd0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL use parameter CLKS_PER_BIT, default 434, meaning CLOCK_50 cycles per bit (115200 baud at 50 MHz); legal range 4..65535.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset, with every flop on the rising edge of CLOCK_50.
REQ-003 Port: CLOCK_50  in  1  system clock (50 MHz).
REQ-004 Port: reset  in  1  synchronous active-high reset.
REQ-005 Port: UART_RXD  in  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 Port: rx_data  out  8  received byte in the holding register.
REQ-007 Port: rx_valid  out  1  holding register full.
REQ-008 Port: rx_ready  in  1  consumer accepts rx_data when high with rx_valid.
REQ-009 Port: frame_err  out  1  one-cycle pulse when a stop bit samples low.
REQ-010 Port: overrun  out  1  sticky; a byte was lost because the holding register was still full.
REQ-011 Port: busy  out  1  high in any state other than IDLE.

Function
REQ-012 UART_RXD SHALL pass through a 2-flop synchronizer; all logic uses only the synchronized value rxs.
REQ-013 The FSM SHALL have states IDLE, START, DATA, STOP and BREAK, plus a 16-bit cycle counter and a 3-bit bit index.
REQ-014 IDLE: when rxs = 0, go to START and clear the counter.
REQ-015 START: at counter = CLKS_PER_BIT/2 - 1 (floor), if rxs = 0 go to DATA with counter and bit index cleared; if rxs = 1 it is a glitch, so return to IDLE with no outputs.
REQ-016 DATA: at counter = CLKS_PER_BIT - 1, sample rxs into shift bit [index] (LSB first) and clear the counter; after index 7, go to STOP; otherwise increment the index.
REQ-017 STOP: at counter = CLKS_PER_BIT - 1, if rxs = 1 commit the byte (REQ-018) and go to IDLE; if rxs = 0, pulse frame_err for exactly 1 cycle, discard the byte and go to BREAK.
REQ-018 Commit SHALL load rx_data and set rx_valid = 1 on the same edge.
REQ-019 If rx_valid = 1 and rx_ready = 0 at commit, rx_data SHALL be overwritten with the new byte and overrun set to 1.
REQ-020 BREAK: remain until rxs = 1, then go to IDLE; a held-low line SHALL produce no further frames or frame_err pulses.
REQ-021 Handshake: when rx_valid = 1 and rx_ready = 1 at an edge, rx_valid SHALL clear next cycle unless a commit occurs on that same edge, in which case rx_valid stays 1 with the new data and overrun is not set.
REQ-022 rx_data SHALL stay stable while rx_valid = 1 except on commit.
REQ-023 overrun SHALL clear only on reset or on an accepting handshake (rx_valid and rx_ready both high).
REQ-024 Latency SHALL be: rx_valid rises 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles (+/-1) after the start-bit falling edge at the UART_RXD pin.
REQ-025 Counter compares SHALL be unsigned 16-bit; the counter never wraps because it is cleared at every compare match.
REQ-026 Back-to-back frames with a start bit immediately after the stop sample SHALL be received without loss.

Reset
REQ-027 While reset = 1 at an edge: state = IDLE; counter and index = 0; rx_data = 8'h00; rx_valid, frame_err, overrun and busy = 0; synchronizer flops = 1.
REQ-028 Reset mid-frame SHALL abort the frame with no commit and no frame_err, and the next falling edge after reset starts a new frame.

Verification (CLKS_PER_BIT = 8)
REQ-029 Send 8'hA5 with a valid stop bit and rx_ready = 0 -> rx_valid rises at 78 +/- 1 cycles; rx_data = 8'hA5; frame_err = 0; overrun = 0.
REQ-030 Leave 8'hA5 unread, then send 8'h3C -> rx_data = 8'h3C, rx_valid = 1, overrun = 1; a later rx_ready pulse clears rx_valid and overrun.
REQ-031 Send 8'h55 with stop bit = 0, then hold the line low for 40 cycles -> exactly one frame_err pulse, rx_valid = 0, busy stays high until the line returns high.
REQ-032 Drive a 2-cycle low glitch on an idle line -> START aborts to IDLE, no rx_valid, no frame_err.
REQ-033 Send bytes 8'h00 and 8'hFF back-to-back with rx_ready = 1 held -> two rx_valid pulses carrying 8'h00 then 8'hFF, overrun = 0.
REQ-034 Assert reset during bit 4 of a frame, then send 8'h81 -> no output from the aborted frame; rx_data = 8'h81 received correctly.
